// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path.
// Holds the FSM state encoding, the 4-bit opcode map, the ALUOp codes that
// feed the ALU control decoder, and small opcode classification helpers.
package cpu_ctrl_pkg;

    // FSM state encoding. The values are fixed so that state dumps are
    // readable against the instruction timing tables.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Opcode map (IR[15:12]).
    localparam logic [3:0] OP_LD       = 4'b0000;
    localparam logic [3:0] OP_ST       = 4'b0001;
    localparam logic [3:0] OP_RTYPE_LO = 4'b0010;
    localparam logic [3:0] OP_RTYPE_HI = 4'b1001;
    localparam logic [3:0] OP_BEQ      = 4'b1010;
    localparam logic [3:0] OP_BNE      = 4'b1011;
    localparam logic [3:0] OP_JMP      = 4'b1100;
    localparam logic [3:0] OP_NOP_A    = 4'b1101;
    localparam logic [3:0] OP_NOP_B    = 4'b1110;
    localparam logic [3:0] OP_HALT     = 4'b1111;

    // ALUOp codes driven to the ALU control decoder.
    localparam logic [1:0] ALUOP_ADDR = 2'b10;
    localparam logic [1:0] ALUOP_CMP  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b00;

    // Width of the memory wait counter; large enough for any MAX_WAIT up to 255.
    localparam int WAIT_W = 8;

    // True for the contiguous R-type ALU opcode range.
    function automatic logic is_rtype(input logic [3:0] op);
        return (op >= OP_RTYPE_LO) && (op <= OP_RTYPE_HI);
    endfunction

    // True for the two opcodes that retire without doing any work.
    function automatic logic is_nop(input logic [3:0] op);
        return (op == OP_NOP_A) || (op == OP_NOP_B);
    endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Bounded-wait watchdog for the instruction/data memory handshakes.
// Counts consecutive cycles in which the controller is waiting on a memory
// ready, and flags timeout on the cycle the count has reached MAX_WAIT while
// still waiting.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   waiting  - controller is in FETCH/MEM and the relevant ready is low
//   timeout  - waiting with the counter at MAX_WAIT (abort this cycle)
module mem_wait_watchdog
    import cpu_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    output logic timeout
);

    localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_r;

    // A ready arriving while the count sits at the limit clears 'waiting',
    // so the normal transition wins over the error.
    assign timeout = waiting && (wait_cnt_r == LIMIT_C);

    // Wait counter: any cycle that is not a continued wait is a state change
    // (ready accepted, timeout abort, or a non-memory state), so it clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (waiting && !timeout) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit CPU with 4-bit opcodes.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives ALUOp plus PC, IR, register-file
// and memory strobes, guards memory handshakes with a watchdog and counts
// retired instructions.
// Ports:
//   clk, rst                 - clock (rising edge), synchronous active-high reset
//   opcode                   - IR[15:12], sampled in DECODE
//   zero                     - ALU zero flag, used in EXEC
//   imem_ready, dmem_ready   - memory handshake completions
//   imem_req, dmem_req, dmem_we          - memory requests
//   ir_load, pc_inc, pc_branch, pc_jump  - IR / PC strobes
//   alu_op, alu_src, reg_dst, reg_write, mem_to_reg - datapath controls
//   halted, bus_err, retired - status
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_branch,
    output logic             pc_jump,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    state_t           state_r;
    state_t           next_state_s;
    logic [3:0]       op_q_r;
    logic [CNT_W-1:0] retired_r;
    logic             bus_err_r;
    logic             retire_s;
    logic             waiting_s;
    logic             timeout_s;

    // Waiting is derived outside the FSM block so the watchdog's timeout can
    // feed next-state logic without forming a combinational loop.
    assign waiting_s = !rst &&
                       (((state_r == ST_FETCH) && !imem_ready) ||
                        ((state_r == ST_MEM)   && !dmem_ready));

    mem_wait_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .waiting (waiting_s),
        .timeout (timeout_s)
    );

    // State, latched opcode, retired counter and sticky bus error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_FETCH;
            op_q_r    <= 4'b0000;
            retired_r <= {CNT_W{1'b0}};
            bus_err_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_DECODE) begin
                op_q_r <= opcode;
            end else begin
                op_q_r <= op_q_r;
            end
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end else begin
                retired_r <= retired_r;
            end
            if (timeout_s) begin
                bus_err_r <= 1'b1;
            end else begin
                bus_err_r <= bus_err_r;
            end
        end
    end

    // Next-state and output decode. While rst is high every strobe stays low,
    // which drops an in-flight request in the same cycle.
    always_comb begin
        next_state_s = state_r;
        retire_s     = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_branch    = 1'b0;
        pc_jump      = 1'b0;
        alu_op       = ALUOP_FUNC;
        alu_src      = 1'b0;
        reg_dst      = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        halted       = 1'b0;

        if (rst) begin
            next_state_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_load      = 1'b1;
                        pc_inc       = 1'b1;
                        next_state_s = ST_DECODE;
                    end else if (timeout_s) begin
                        next_state_s = ST_HALT;
                    end else begin
                        next_state_s = ST_FETCH;
                    end
                end

                // Routing uses the live opcode; op_q is only valid from EXEC on.
                ST_DECODE: begin
                    if (opcode == OP_HALT) begin
                        next_state_s = ST_HALT;
                    end else if (is_nop(opcode)) begin
                        retire_s     = 1'b1;
                        next_state_s = ST_FETCH;
                    end else begin
                        next_state_s = ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    case (op_q_r)
                        OP_LD, OP_ST: begin
                            alu_op       = ALUOP_ADDR;
                            alu_src      = 1'b1;
                            next_state_s = ST_MEM;
                        end
                        OP_BEQ: begin
                            alu_op       = ALUOP_CMP;
                            pc_branch    = zero;
                            retire_s     = 1'b1;
                            next_state_s = ST_FETCH;
                        end
                        OP_BNE: begin
                            alu_op       = ALUOP_CMP;
                            pc_branch    = !zero;
                            retire_s     = 1'b1;
                            next_state_s = ST_FETCH;
                        end
                        OP_JMP: begin
                            pc_jump      = 1'b1;
                            retire_s     = 1'b1;
                            next_state_s = ST_FETCH;
                        end
                        default: begin
                            // Only R-type can land here; NOP/HALT never enter EXEC.
                            if (is_rtype(op_q_r)) begin
                                alu_op       = ALUOP_FUNC;
                                alu_src      = 1'b0;
                                next_state_s = ST_WB;
                            end else begin
                                next_state_s = ST_FETCH;
                            end
                        end
                    endcase
                end

                // Address operands are held so the memory sees a stable address.
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (op_q_r == OP_ST);
                    alu_op   = ALUOP_ADDR;
                    alu_src  = 1'b1;
                    if (dmem_ready) begin
                        if (op_q_r == OP_ST) begin
                            retire_s     = 1'b1;
                            next_state_s = ST_FETCH;
                        end else begin
                            next_state_s = ST_WB;
                        end
                    end else if (timeout_s) begin
                        next_state_s = ST_HALT;
                    end else begin
                        next_state_s = ST_MEM;
                    end
                end

                ST_WB: begin
                    reg_write    = 1'b1;
                    mem_to_reg   = (op_q_r == OP_LD);
                    reg_dst      = is_rtype(op_q_r);
                    retire_s     = 1'b1;
                    next_state_s = ST_FETCH;
                end

                ST_HALT: begin
                    halted       = 1'b1;
                    next_state_s = ST_HALT;
                end

                default: begin
                    next_state_s = ST_FETCH;
                end
            endcase
        end
    end

    assign retired = retired_r;
    assign bus_err = bus_err_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MAX_WAIT=15, CNT_W=16).
// Inputs change 1 time unit after each rising edge; outputs are checked 2
// units later, well before the next edge.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_load;
    logic        pc_inc;
    logic        pc_branch;
    logic        pc_jump;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        reg_dst;
    logic        reg_write;
    logic        mem_to_reg;
    logic        halted;
    logic        bus_err;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .MAX_WAIT (15),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .pc_branch  (pc_branch),
        .pc_jump    (pc_jump),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .bus_err    (bus_err),
        .retired    (retired)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        opcode     = 4'b0000;
        zero       = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        tick();
        tick();
        settle();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_retired",  32'(retired),  32'd0);
        check("rst_bus_err",  32'(bus_err),  32'd0);
        check("rst_halted",   32'(halted),   32'd0);

        // R-type 0010, zero wait states: FETCH, DECODE, EXEC, WB
        tick(); rst = 1'b0; imem_ready = 1'b1; opcode = 4'b0010; settle();
        check("r_c0_ir_load",  32'(ir_load),  32'd1);
        check("r_c0_pc_inc",   32'(pc_inc),   32'd1);
        check("r_c0_imem_req", 32'(imem_req), 32'd1);
        tick(); settle();
        check("r_c1_ir_load",  32'(ir_load),  32'd0);
        check("r_c1_imem_req", 32'(imem_req), 32'd0);
        tick(); settle();
        check("r_c2_alu_op",    32'(alu_op),    32'd0);
        check("r_c2_alu_src",   32'(alu_src),   32'd0);
        check("r_c2_reg_write", 32'(reg_write), 32'd0);
        tick(); settle();
        check("r_c3_reg_write",  32'(reg_write),  32'd1);
        check("r_c3_reg_dst",    32'(reg_dst),    32'd1);
        check("r_c3_mem_to_reg", 32'(mem_to_reg), 32'd0);
        check("r_c3_retired",    32'(retired),    32'd0);

        // LD with dmem_ready two cycles late: 7 cycles total
        tick(); opcode = 4'b0000; settle();
        check("r_retired",      32'(retired),   32'd1);
        check("r_c4_reg_write", 32'(reg_write), 32'd0);
        check("ld_c0_ir_load",  32'(ir_load),   32'd1);
        tick(); settle();
        tick(); dmem_ready = 1'b0; settle();
        check("ld_exec_alu_op",   32'(alu_op),   32'd2);
        check("ld_exec_alu_src",  32'(alu_src),  32'd1);
        check("ld_exec_dmem_req", 32'(dmem_req), 32'd0);
        tick(); settle();
        check("ld_m1_dmem_req", 32'(dmem_req), 32'd1);
        check("ld_m1_dmem_we",  32'(dmem_we),  32'd0);
        check("ld_m1_alu_op",   32'(alu_op),   32'd2);
        tick(); settle();
        check("ld_m2_dmem_req", 32'(dmem_req), 32'd1);
        tick(); dmem_ready = 1'b1; settle();
        check("ld_m3_dmem_req", 32'(dmem_req), 32'd1);
        tick(); dmem_ready = 1'b0; settle();
        check("ld_wb_reg_write",  32'(reg_write),  32'd1);
        check("ld_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
        check("ld_wb_reg_dst",    32'(reg_dst),    32'd0);
        check("ld_wb_dmem_req",   32'(dmem_req),   32'd0);
        check("ld_wb_retired",    32'(retired),    32'd1);

        // BEQ with zero=1: branch taken
        tick(); opcode = 4'b1010; zero = 1'b1; settle();
        check("ld_retired", 32'(retired), 32'd2);
        tick(); settle();
        check("beq_dec_pc_branch", 32'(pc_branch), 32'd0);
        tick(); settle();
        check("beq_pc_branch", 32'(pc_branch), 32'd1);
        check("beq_alu_op",    32'(alu_op),    32'd1);

        // BNE with zero=1: not taken; flipping zero makes it taken
        tick(); opcode = 4'b1011; settle();
        check("beq_retired",         32'(retired),   32'd3);
        check("bne_fetch_pc_branch", 32'(pc_branch), 32'd0);
        tick(); settle();
        tick(); settle();
        check("bne_z1_pc_branch", 32'(pc_branch), 32'd0);
        check("bne_alu_op",       32'(alu_op),    32'd1);
        zero = 1'b0; settle();
        check("bne_z0_pc_branch", 32'(pc_branch), 32'd1);

        // JMP
        tick(); opcode = 4'b1100; settle();
        check("bne_retired", 32'(retired), 32'd4);
        tick(); settle();
        tick(); settle();
        check("jmp_pc_jump",   32'(pc_jump),   32'd1);
        check("jmp_pc_branch", 32'(pc_branch), 32'd0);

        // NOP: 2 cycles, retires
        tick(); opcode = 4'b1101; settle();
        check("jmp_retired",       32'(retired), 32'd5);
        check("jmp_fetch_pc_jump", 32'(pc_jump), 32'd0);
        tick(); settle();
        check("nop_dec_imem_req", 32'(imem_req), 32'd0);
        check("nop_dec_retired",  32'(retired),  32'd5);

        // HALT instruction: not counted, absorbing
        tick(); opcode = 4'b1111; settle();
        check("nop_retired",        32'(retired),  32'd6);
        check("nop_fetch_imem_req", 32'(imem_req), 32'd1);
        tick(); settle();
        tick(); settle();
        check("halt_halted",   32'(halted),   32'd1);
        check("halt_imem_req", 32'(imem_req), 32'd0);
        check("halt_retired",  32'(retired),  32'd6);
        check("halt_bus_err",  32'(bus_err),  32'd0);
        tick(); tick(); tick(); settle();
        check("halt_sticky",         32'(halted),  32'd1);
        check("halt_sticky_retired", 32'(retired), 32'd6);

        // rst leaves HALT, counter cleared
        rst = 1'b1;
        tick(); rst = 1'b0; imem_ready = 1'b0; settle();
        check("halt_rst_retired",  32'(retired),  32'd0);
        check("halt_rst_halted",   32'(halted),   32'd0);
        check("halt_rst_imem_req", 32'(imem_req), 32'd1);

        // imem_ready held low: error after 16 FETCH cycles
        for (int i = 0; i < 15; i++) begin
            tick(); settle();
        end
        check("to_c16_imem_req", 32'(imem_req), 32'd1);
        check("to_c16_bus_err",  32'(bus_err),  32'd0);
        check("to_c16_halted",   32'(halted),   32'd0);
        tick(); settle();
        check("to_halted",   32'(halted),   32'd1);
        check("to_bus_err",  32'(bus_err),  32'd1);
        check("to_imem_req", 32'(imem_req), 32'd0);

        // Reset, then ready on the 16th FETCH cycle wins: no error
        tick(); rst = 1'b1; settle();
        tick(); rst = 1'b0; settle();
        check("rdy_rst_bus_err", 32'(bus_err), 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick(); settle();
        end
        imem_ready = 1'b1; opcode = 4'b0001; settle();
        check("rdy16_ir_load", 32'(ir_load), 32'd1);
        tick(); settle();
        check("rdy16_bus_err",  32'(bus_err),  32'd0);
        check("rdy16_halted",   32'(halted),   32'd0);
        check("rdy16_imem_req", 32'(imem_req), 32'd0);

        // ST, rst during a MEM wait cycle drops the request at once
        tick(); dmem_ready = 1'b0; settle();
        tick(); settle();
        check("st_m1_dmem_req", 32'(dmem_req), 32'd1);
        check("st_m1_dmem_we",  32'(dmem_we),  32'd1);
        tick(); rst = 1'b1; settle();
        check("st_rst_dmem_req", 32'(dmem_req), 32'd0);
        check("st_rst_dmem_we",  32'(dmem_we),  32'd0);
        tick(); rst = 1'b0; imem_ready = 1'b0; settle();
        check("st_rst_fetch_imem_req", 32'(imem_req), 32'd1);
        check("st_rst_bus_err",        32'(bus_err),  32'd0);
        check("st_rst_retired",        32'(retired),  32'd0);
        check("st_rst_dmem_req_after", 32'(dmem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
